i8035_xbus_master: RTL and testbench

Sequential bus-cycle generator for the sound CPU's external bus: the initiator side of the ALE / PSENn / RDn multiplexed-bus protocol that the sound interface answers. It accepts single fetch, read and write requests from the sound CPU core. For each request it runs one address-latch phase, one address-hold phase and one strobe phase on the shared 8-bit bus, then returns read data with a one-cycle acknowledge.

---
 rtl/i8035_bus_pkg.sv | 29 ++
 rtl/i8035_xbus_master.sv | 193 +++++++++++++++++++
 tb/tb_i8035_xbus_master.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i8035_bus_pkg.sv
// Shared definitions for the sound CPU external bus master.
// Request kinds, FSM state encoding and timing parameter limits.
package i8035_bus_pkg;

   localparam logic [1:0] KIND_FETCH = 2'd0;
   localparam logic [1:0] KIND_READ  = 2'd1;
   localparam logic [1:0] KIND_WRITE = 2'd2;
   localparam logic [1:0] KIND_ADDR  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALE,
      ST_AHOLD,
      ST_STROBE,
      ST_END
   } state_t;

   localparam int ALE_W_MIN = 1;
   localparam int ALE_W_MAX = 15;
   localparam int AH_W_MIN  = 1;
   localparam int AH_W_MAX  = 15;
   localparam int STB_W_MIN = 3;
   localparam int STB_W_MAX = 15;

   function automatic logic [3:0] cnt_load(input int w);
      return 4'(w - 1);
   endfunction

endpackage

// File: rtl/i8035_xbus_master.sv
// Bus-cycle generator for the sound CPU ALE/PSENn/RDn/WRn multiplexed bus.
// Ports: I_CLK, I_RST (async high), I_REQ/I_KIND/I_ADDR/I_WDATA request,
// O_BUSY/O_ACK/O_RDATA status, O_ALE/O_PSENn/O_RDn/O_WRn strobes,
// O_DB_O/O_DB_OE/I_DB_I data bus, O_P2_A upper address.
module i8035_xbus_master
   import i8035_bus_pkg::*;
#(
   parameter int ALE_W = 2,
   parameter int AH_W  = 1,
   parameter int STB_W = 4
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic        I_REQ,
   input  logic [1:0]  I_KIND,
   input  logic [11:0] I_ADDR,
   input  logic [7:0]  I_WDATA,
   output logic        O_BUSY,
   output logic        O_ACK,
   output logic [7:0]  O_RDATA,
   output logic        O_ALE,
   output logic        O_PSENn,
   output logic        O_RDn,
   output logic        O_WRn,
   output logic [7:0]  O_DB_O,
   output logic        O_DB_OE,
   input  logic [7:0]  I_DB_I,
   output logic [3:0]  O_P2_A
);

   // The responder returns registered data two clocks into the strobe,
   // so shorter strobes would sample stale bus contents.
   if (ALE_W < ALE_W_MIN || ALE_W > ALE_W_MAX) begin : g_bad_ale
      $error("ALE_W out of range");
   end
   if (AH_W < AH_W_MIN || AH_W > AH_W_MAX) begin : g_bad_ah
      $error("AH_W out of range");
   end
   if (STB_W < STB_W_MIN || STB_W > STB_W_MAX) begin : g_bad_stb
      $error("STB_W out of range");
   end

   localparam logic [3:0] CNT_ALE = cnt_load(ALE_W);
   localparam logic [3:0] CNT_AH  = cnt_load(AH_W);
   localparam logic [3:0] CNT_STB = cnt_load(STB_W);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [1:0]  kind_q, kind_n;
   logic [11:0] addr_q, addr_n;
   logic [7:0]  wdata_q, wdata_n;

   logic        ale_d, psen_d, rd_d, wr_d, oe_d;
   logic [7:0]  db_d;
   logic [3:0]  p2_d;
   logic        sample;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      kind_n  = kind_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      unique case (state)
         ST_IDLE: begin
            if (I_REQ) begin
               state_n = ST_ALE;
               cnt_n   = CNT_ALE;
               kind_n  = I_KIND;
               addr_n  = I_ADDR;
               wdata_n = I_WDATA;
            end
         end
         ST_ALE: begin
            if (cnt == 4'd0) begin
               state_n = ST_AHOLD;
               cnt_n   = CNT_AH;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         ST_AHOLD: begin
            if (cnt == 4'd0) begin
               if (kind_q == KIND_ADDR) begin
                  state_n = ST_END;
                  cnt_n   = 4'd0;
               end else begin
                  state_n = ST_STROBE;
                  cnt_n   = CNT_STB;
               end
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt == 4'd0) begin
               state_n = ST_END;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         ST_END: begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they appear registered
   // in the same cycle the state takes effect.
   always_comb begin
      ale_d  = 1'b0;
      psen_d = 1'b1;
      rd_d   = 1'b1;
      wr_d   = 1'b1;
      oe_d   = 1'b0;
      db_d   = O_DB_O;
      p2_d   = O_P2_A;
      unique case (state_n)
         ST_ALE: begin
            ale_d = 1'b1;
            oe_d  = 1'b1;
            db_d  = addr_n[7:0];
            p2_d  = addr_n[11:8];
         end
         ST_AHOLD: begin
            oe_d = 1'b1;
            db_d = addr_n[7:0];
            p2_d = addr_n[11:8];
         end
         ST_STROBE: begin
            unique case (1'b1)
               (kind_n == KIND_FETCH): psen_d = 1'b0;
               (kind_n == KIND_READ):  rd_d   = 1'b0;
               (kind_n == KIND_WRITE): begin
                  wr_d = 1'b0;
                  oe_d = 1'b1;
                  db_d = wdata_n;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign sample = (state == ST_STROBE) && (cnt == 4'd0) &&
                   ((kind_q == KIND_FETCH) || (kind_q == KIND_READ));

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         kind_q  <= KIND_FETCH;
         addr_q  <= 12'd0;
         wdata_q <= 8'd0;
         O_BUSY  <= 1'b0;
         O_ACK   <= 1'b0;
         O_RDATA <= 8'd0;
         O_ALE   <= 1'b0;
         O_PSENn <= 1'b1;
         O_RDn   <= 1'b1;
         O_WRn   <= 1'b1;
         O_DB_O  <= 8'd0;
         O_DB_OE <= 1'b0;
         O_P2_A  <= 4'd0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         kind_q  <= kind_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         O_BUSY  <= (state_n != ST_IDLE);
         O_ACK   <= (state_n == ST_END);
         O_ALE   <= ale_d;
         O_PSENn <= psen_d;
         O_RDn   <= rd_d;
         O_WRn   <= wr_d;
         O_DB_O  <= db_d;
         O_DB_OE <= oe_d;
         O_P2_A  <= p2_d;
         if (sample) begin
            O_RDATA <= I_DB_I;
         end
      end
   end

endmodule

// File: tb/tb_i8035_xbus_master.sv
// Self-checking bench for i8035_xbus_master.
// Two instances: default timing and ALE_W=1/AH_W=2/STB_W=3.
module tb_i8035_xbus_master;

   typedef struct packed {
      logic       busy;
      logic       ack;
      logic       ale;
      logic       psen;
      logic       rd;
      logic       wr;
      logic       oe;
      logic [7:0] db;
      logic [3:0] p2;
      logic [7:0] rdata;
   } obs_t;

   typedef struct {
      int         sel;
      logic [1:0] kind;
      logic [11:0] addr;
      logic [7:0] wdata;
      logic [7:0] rsp;
      int         ack_cyc;
      logic [7:0] rdata;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  kind;
   logic [11:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  dbi [2];
   logic [1:0]  busy, ack, ale, psen, rdn, wrn, oe;
   logic [7:0]  dbo [2];
   logic [7:0]  rdata [2];
   logic [3:0]  p2 [2];

   int checks;
   int errors;
   logic [7:0] rd_m [2];

   i8035_xbus_master u_dut0 (
      .I_CLK(clk), .I_RST(rst), .I_REQ(req[0]), .I_KIND(kind),
      .I_ADDR(addr), .I_WDATA(wdata), .O_BUSY(busy[0]), .O_ACK(ack[0]),
      .O_RDATA(rdata[0]), .O_ALE(ale[0]), .O_PSENn(psen[0]),
      .O_RDn(rdn[0]), .O_WRn(wrn[0]), .O_DB_O(dbo[0]),
      .O_DB_OE(oe[0]), .I_DB_I(dbi[0]), .O_P2_A(p2[0])
   );

   i8035_xbus_master #(.ALE_W(1), .AH_W(2), .STB_W(3)) u_dut1 (
      .I_CLK(clk), .I_RST(rst), .I_REQ(req[1]), .I_KIND(kind),
      .I_ADDR(addr), .I_WDATA(wdata), .O_BUSY(busy[1]), .O_ACK(ack[1]),
      .O_RDATA(rdata[1]), .O_ALE(ale[1]), .O_PSENn(psen[1]),
      .O_RDn(rdn[1]), .O_WRn(wrn[1]), .O_DB_O(dbo[1]),
      .O_DB_OE(oe[1]), .I_DB_I(dbi[1]), .O_P2_A(p2[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pa(input int sel);
      return (sel != 0) ? 1 : 2;
   endfunction
   function automatic int ph(input int sel);
      return (sel != 0) ? 2 : 1;
   endfunction
   function automatic int ps(input int sel);
      return (sel != 0) ? 3 : 4;
   endfunction

   function automatic obs_t get_obs(input int sel);
      obs_t o;
      o.busy  = busy[sel];
      o.ack   = ack[sel];
      o.ale   = ale[sel];
      o.psen  = psen[sel];
      o.rd    = rdn[sel];
      o.wr    = wrn[sel];
      o.oe    = oe[sel];
      o.db    = dbo[sel];
      o.p2    = p2[sel];
      o.rdata = rdata[sel];
      return o;
   endfunction

   // Expected bus state in cycle c after acceptance, from the phase widths.
   function automatic obs_t model(input int c, input int a, input int h,
                                  input int s, input logic [1:0] k,
                                  input logic [11:0] ad,
                                  input logic [7:0] wd,
                                  input logic [7:0] rsp,
                                  input logic [7:0] rprev);
      obs_t e;
      int   t;
      bit   in_stb;
      t      = a + h + ((k == 2'd3) ? 0 : s) + 1;
      in_stb = (k != 2'd3) && (c > a + h) && (c <= a + h + s);
      e.busy  = (c >= 1) && (c <= t);
      e.ack   = (c == t);
      e.ale   = (c >= 1) && (c <= a);
      e.psen  = !(in_stb && k == 2'd0);
      e.rd    = !(in_stb && k == 2'd1);
      e.wr    = !(in_stb && k == 2'd2);
      e.oe    = ((c >= 1) && (c <= a + h)) || (in_stb && k == 2'd2);
      e.db    = (c <= a + h) ? ad[7:0] : wd;
      e.p2    = ad[11:8];
      e.rdata = (c >= t && k < 2'd2) ? rsp : rprev;
      return e;
   endfunction

   task automatic chk(input string nm, input obs_t a, input obs_t e,
                      input bit mask_db);
      checks++;
      if (mask_db && !e.oe) begin
         a.db = 8'h00;
         e.db = 8'h00;
      end
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic chk_bits(input string nm, input logic [7:0] a,
                           input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   function automatic obs_t reset_obs();
      obs_t e;
      e = '0;
      e.psen = 1'b1;
      e.rd   = 1'b1;
      e.wr   = 1'b1;
      return e;
   endfunction

   // Entered at the #1 point of an idle cycle; returns at the same point
   // of the first idle cycle after the transfer.
   task automatic run_req(input int sel, input logic [1:0] k,
                          input logic [11:0] ad, input logic [7:0] wd,
                          input logic [7:0] rsp, input string nm,
                          output int ack_c, output logic [7:0] rd_at);
      int   a, h, s, t, last;
      obs_t e;
      a     = pa(sel);
      h     = ph(sel);
      s     = ps(sel);
      t     = a + h + ((k == 2'd3) ? 0 : s) + 1;
      last  = a + h + s;
      ack_c = 0;
      rd_at = 8'h00;
      kind  = k;
      addr  = ad;
      wdata = wd;
      req[sel] = 1'b1;
      for (int c = 1; c <= t + 1; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            req[sel] = 1'b0;
            kind  = 2'($urandom);
            addr  = ~ad;
            wdata = ~wd;
         end
         dbi[sel] = (c == last) ? rsp : ~rsp;
         e = model(c, a, h, s, k, ad, wd, rsp, rd_m[sel]);
         chk($sformatf("%s c%0d", nm, c), get_obs(sel), e, 1'b1);
         if (ack[sel] === 1'b1 && ack_c == 0) begin
            ack_c = c;
            rd_at = rdata[sel];
         end
      end
      if (k < 2'd2) rd_m[sel] = rsp;
   endtask

   vec_t vt [8];
   int   ac;
   logic [7:0] rv;

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      req    = 2'b00;
      kind   = 2'd0;
      addr   = 12'h000;
      wdata  = 8'h00;
      dbi[0] = 8'h00;
      dbi[1] = 8'h00;
      rd_m[0] = 8'h00;
      rd_m[1] = 8'h00;

      vt[0] = '{0, 2'd0, 12'h5A3, 8'h00, 8'h3C, 8, 8'h3C};
      vt[1] = '{0, 2'd2, 12'h012, 8'h07, 8'hEE, 8, 8'h3C};
      vt[2] = '{0, 2'd1, 12'h0FF, 8'h99, 8'hA5, 8, 8'hA5};
      vt[3] = '{0, 2'd3, 12'hC40, 8'h11, 8'h22, 4, 8'hA5};
      vt[4] = '{1, 2'd1, 12'h7E1, 8'h00, 8'h5B, 7, 8'h5B};
      vt[5] = '{1, 2'd3, 12'h9AB, 8'h00, 8'h66, 4, 8'h5B};
      vt[6] = '{1, 2'd0, 12'h3C7, 8'h00, 8'h81, 7, 8'h81};
      vt[7] = '{1, 2'd2, 12'hE5D, 8'hD2, 8'h44, 7, 8'h81};

      @(posedge clk);
      #1;
      chk("reset0", get_obs(0), reset_obs(), 1'b0);
      chk("reset1", get_obs(1), reset_obs(), 1'b0);
      rst = 1'b0;

      foreach (vt[i]) begin
         run_req(vt[i].sel, vt[i].kind, vt[i].addr, vt[i].wdata,
                 vt[i].rsp, $sformatf("vec%0d", i), ac, rv);
         chk_bits($sformatf("vec%0d ack_cycle", i), 8'(ac),
                  8'(vt[i].ack_cyc));
         chk_bits($sformatf("vec%0d rdata", i), rv, vt[i].rdata);
      end

      // Held request: second transfer latched from inputs after cycle 9.
      begin
         obs_t e;
         kind = 2'd1;
         addr = 12'h100;
         req[0] = 1'b1;
         for (int c = 1; c <= 19; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) addr = 12'h101;
            if (c == 10) req[0] = 1'b0;
            dbi[0] = (c == 7) ? 8'hC1 : (c == 16) ? 8'h2D : 8'hFF;
            if (c <= 9)
               e = model(c, 2, 1, 4, 2'd1, 12'h100, 8'h00, 8'hC1,
                         rd_m[0]);
            else
               e = model(c - 9, 2, 1, 4, 2'd1, 12'h101, 8'h00, 8'h2D,
                         8'hC1);
            chk($sformatf("b2b c%0d", c), get_obs(0), e, 1'b1);
         end
         rd_m[0] = 8'h2D;
      end

      // Reset in cycle 5 of a read, then a request on the first free edge.
      begin
         obs_t e;
         obs_t a;
         kind = 2'd1;
         addr = 12'h2C4;
         req[0] = 1'b1;
         for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) req[0] = 1'b0;
            dbi[0] = 8'h77;
            e = model(c, 2, 1, 4, 2'd1, 12'h2C4, 8'h00, 8'h77, rd_m[0]);
            chk($sformatf("rstmid c%0d", c), get_obs(0), e, 1'b1);
         end
         #1 rst = 1'b1;
         #1;
         a = get_obs(0);
         chk_bits("rstmid rd_oe_busy", {5'd0, a.rd, a.oe, a.busy},
                  8'b0000_0100);
         chk("rstmid all", a, reset_obs(), 1'b0);
         rd_m[0] = 8'h00;
         rd_m[1] = 8'h00;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_bits($sformatf("rst hold ack c%0d", c), {7'd0, ack[0]},
                     8'd0);
         end
         rst = 1'b0;
         run_req(0, 2'd1, 12'h6B9, 8'h00, 8'h4E, "post_rst", ac, rv);
         chk_bits("post_rst ack_cycle", 8'(ac), 8'd8);
         chk_bits("post_rst rdata", rv, 8'h4E);
      end

      for (int n = 0; n < 40; n++) begin
         int         sel;
         int         gap;
         logic [1:0] k;
         logic [11:0] ad;
         logic [7:0] wd, rsp;
         sel = int'($urandom_range(0, 1));
         k   = 2'($urandom_range(0, 3));
         ad  = 12'($urandom);
         wd  = 8'($urandom);
         rsp = 8'($urandom);
         run_req(sel, k, ad, wd, rsp, $sformatf("rnd%0d", n), ac, rv);
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            chk_bits($sformatf("rnd%0d idle", n),
                     {6'd0, busy[sel], ack[sel]}, 8'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
